gcla_addsub_seq: RTL and testbench

Parametrised, group-serial carry-lookahead adder/subtractor. Each clock processes one GROUP-bit lookahead group, with the group carry registered between groups, so wide operands reuse one small CLA slice. It generalises the team's fixed 8-bit combinational GCLA add/sub in three ways: configurable width, a start/done handshake, and signed-overflow reporting. It sits in the term-project datapath between the operand registers and the result/display logic.

---
 rtl/addsub_pkg.sv | 26 ++
 rtl/cla_group.sv | 52 +++++
 rtl/gcla_addsub_seq.sv | 128 ++++++++++++
 tb/tb_gcla_addsub_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the group-serial CLA adder/subtractor.
package addsub_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int GROUP_DEFAULT = 4;
   localparam int MAX_GROUP     = 32;

   // Group generate/propagate over the low n bits of zero-padded p/g vectors.
   function automatic logic [1:0] group_gp(input logic [MAX_GROUP-1:0] p,
                                           input logic [MAX_GROUP-1:0] g,
                                           input int n);
      logic gg;
      logic pp;
      gg = 1'b0;
      pp = 1'b1;
      for (int i = 0; i < MAX_GROUP; i++) begin
         if (i < n) begin
            gg = g[i] | (p[i] & gg);
            pp = pp & p[i];
         end
      end
      return {gg, pp};
   endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead slice: sum, group G/P, and the carry into the slice MSB.
module cla_group
   import addsub_pkg::*;
#(
   parameter int GROUP = GROUP_DEFAULT
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             cin,
   output logic [GROUP-1:0] sum,
   output logic             G,
   output logic             P,
   output logic             c_msb
);

   logic [GROUP-1:0]     p;
   logic [GROUP-1:0]     g;
   logic [GROUP-1:0]     c;
   logic [MAX_GROUP-1:0] p_ext;
   logic [MAX_GROUP-1:0] g_ext;

   assign p = a ^ b;
   assign g = a & b;

   // Each carry is a flat sum of products of g, p and cin, so no carry waits on its neighbour.
   always_comb begin
      logic cc;
      logic pr;
      c = '0;
      for (int i = 0; i < GROUP; i++) begin
         cc = 1'b0;
         pr = 1'b1;
         for (int j = i - 1; j >= 0; j--) begin
            cc = cc | (pr & g[j]);
            pr = pr & p[j];
         end
         c[i] = cc | (pr & cin);
      end
   end

   always_comb begin
      p_ext = '0;
      g_ext = '0;
      p_ext[GROUP-1:0] = p;
      g_ext[GROUP-1:0] = g;
   end

   assign sum      = p ^ c;
   assign c_msb    = c[GROUP-1];
   assign {G, P}   = group_gp(p_ext, g_ext, GROUP);

endmodule

// File: rtl/gcla_addsub_seq.sv
// Group-serial CLA adder/subtractor with start/done handshake and signed overflow.
// Optional macro ADDSUB_SAT_EN: saturate the low WIDTH bits of R on signed overflow.
module gcla_addsub_seq
   import addsub_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int GROUP     = GROUP_DEFAULT,
   parameter int OUT_WIDTH = 2 * WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 Add_Sub,
   output logic                 ready,
   output logic                 done,
   output logic [OUT_WIDTH-1:0] R,
   output logic                 Cout,
   output logic                 Ovf
);

   localparam int              N      = WIDTH / GROUP;
   localparam int              KW     = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0]   K_LAST = KW'(N - 1);

   state_t               state;
   logic [KW-1:0]        k;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic                 sub_q;
   logic                 carry_q;

   logic [GROUP-1:0]     slice_a;
   logic [GROUP-1:0]     slice_b;
   logic [GROUP-1:0]     slice_sum;
   logic                 g_grp;
   logic                 p_grp;
   logic                 c_msb;
   logic                 carry_next;
   logic                 ovf_next;
   logic                 last_grp;
   logic [WIDTH-1:0]     low_next;
   logic [OUT_WIDTH-1:0] r_next;

   assign slice_a    = a_q[k*GROUP +: GROUP];
   assign slice_b    = b_q[k*GROUP +: GROUP] ^ {GROUP{sub_q}};
   assign carry_next = g_grp | (p_grp & carry_q);
   assign ovf_next   = c_msb ^ carry_next;
   assign last_grp   = (k == K_LAST);

   cla_group #(.GROUP(GROUP)) u_cla (
      .a     (slice_a),
      .b     (slice_b),
      .cin   (carry_q),
      .sum   (slice_sum),
      .G     (g_grp),
      .P     (p_grp),
      .c_msb (c_msb)
   );

   always_comb begin
      low_next = R[WIDTH-1:0];
      low_next[k*GROUP +: GROUP] = slice_sum;
`ifdef ADDSUB_SAT_EN
      // A wrapped MSB of 1 on overflow means the true result was positive, and vice versa.
      if (last_grp && ovf_next) begin
         low_next = low_next[WIDTH-1] ? ({WIDTH{1'b1}} >> 1) : ~({WIDTH{1'b1}} >> 1);
      end
`endif
      r_next = {OUT_WIDTH{low_next[WIDTH-1]}};
      r_next[WIDTH-1:0] = low_next;
   end

   // NOTE: every register here uses <= so all state updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         k       <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         R       <= '0;
         Cout    <= 1'b0;
         Ovf     <= 1'b0;
         done    <= 1'b0;
         ready   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  sub_q   <= Add_Sub;
                  carry_q <= Add_Sub;
                  k       <= '0;
                  ready   <= 1'b0;
                  state   <= RUN;
               end
            end
            RUN: begin
               carry_q <= carry_next;
               R       <= r_next;
               if (last_grp) begin
                  Cout  <= carry_next;
                  Ovf   <= ovf_next;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gcla_addsub_seq.sv
// Self-checking bench for gcla_addsub_seq (WIDTH=8, GROUP=4); honours ADDSUB_SAT_EN.
module tb_gcla_addsub_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  A;
   logic [7:0]  B;
   logic        Add_Sub;
   logic        ready;
   logic        done;
   logic [15:0] R;
   logic        Cout;
   logic        Ovf;

   int n_vec  = 0;
   int n_miss = 0;

   gcla_addsub_seq #(.WIDTH(8), .GROUP(4), .OUT_WIDTH(16)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .A       (A),
      .B       (B),
      .Add_Sub (Add_Sub),
      .ready   (ready),
      .done    (done),
      .R       (R),
      .Cout    (Cout),
      .Ovf     (Ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        sub;
      logic [15:0] r;
      logic        cout;
      logic        ovf;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                 output logic [15:0] r, output logic c, output logic o);
      int         sa;
      int         sb;
      int         sr;
      logic [8:0] full;
      logic [7:0] low;
      full = s ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});
      c    = full[8];
      sa   = int'($signed(a));
      sb   = int'($signed(b));
      sr   = s ? sa - sb : sa + sb;
      o    = (sr > 127) || (sr < -128);
      low  = full[7:0];
`ifdef ADDSUB_SAT_EN
      if (o) low = (sr > 127) ? 8'h7F : 8'h80;
`endif
      r = {{8{low[7]}}, low};
   endfunction

   task automatic run_and_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                                input logic s, input logic [15:0] exp_r,
                                input logic exp_c, input logic exp_o);
      int lat;
      @(negedge clk);
      check({tag, " ready_before"}, 32'(ready), 32'd1);
      A = a; B = b; Add_Sub = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A = 8'($urandom); B = 8'($urandom); Add_Sub = 1'($urandom);
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'd3);
      check({tag, " R"},       32'(R),    32'(exp_r));
      check({tag, " Cout"},    32'(Cout), 32'(exp_c));
      check({tag, " Ovf"},     32'(Ovf),  32'(exp_o));
      @(negedge clk);
      check({tag, " done_pulse"}, 32'({done, ready}), 32'b01);
      check({tag, " R_hold"},     32'(R),             32'(exp_r));
   endtask

   vec_t        vt[9];
   logic [15:0] er;
   logic        ec;
   logic        eo;

   initial begin
      reset = 1'b1; start = 1'b0; A = '0; B = '0; Add_Sub = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_state", 32'({ready, done, Cout, Ovf, R}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));
      reset = 1'b0;

      vt[0] = '{8'h05, 8'h03, 1'b0, 16'h0008, 1'b0, 1'b0};
      vt[1] = '{8'h03, 8'h05, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vt[2] = '{8'h05, 8'h03, 1'b1, 16'h0002, 1'b1, 1'b0};
      vt[3] = '{8'hFF, 8'h01, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[4] = '{8'h00, 8'h00, 1'b1, 16'h0000, 1'b1, 1'b0};
`ifdef ADDSUB_SAT_EN
      vt[5] = '{8'h7F, 8'h01, 1'b0, 16'h007F, 1'b0, 1'b1};
      vt[6] = '{8'h80, 8'h01, 1'b1, 16'hFF80, 1'b1, 1'b1};
      vt[7] = '{8'h80, 8'h80, 1'b0, 16'hFF80, 1'b1, 1'b1};
      vt[8] = '{8'h7F, 8'hFF, 1'b1, 16'h007F, 1'b0, 1'b1};
`else
      vt[5] = '{8'h7F, 8'h01, 1'b0, 16'hFF80, 1'b0, 1'b1};
      vt[6] = '{8'h80, 8'h01, 1'b1, 16'h007F, 1'b1, 1'b1};
      vt[7] = '{8'h80, 8'h80, 1'b0, 16'h0000, 1'b1, 1'b1};
      vt[8] = '{8'h7F, 8'hFF, 1'b1, 16'hFF80, 1'b0, 1'b1};
`endif
      for (int i = 0; i < 9; i++) begin
         run_and_check($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].sub,
                       vt[i].r, vt[i].cout, vt[i].ovf);
      end

      for (int i = 0; i < 40; i++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         logic       rs;
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom);
         model(ra, rb, rs, er, ec, eo);
         run_and_check($sformatf("rand%0d", i), ra, rb, rs, er, ec, eo);
      end

      // Reset in the first RUN cycle discards the operation.
      begin
         int nd;
         nd = 0;
         @(negedge clk);
         A = 8'h12; B = 8'h34; Add_Sub = 1'b0; start = 1'b1;
         @(negedge clk);
         start = 1'b0; reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         check("midrun_reset", 32'({ready, done, Cout, Ovf, R}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) nd++;
         end
         check("midrun_no_done", 32'(nd), 32'd0);
         model(8'h21, 8'h43, 1'b1, er, ec, eo);
         run_and_check("after_reset", 8'h21, 8'h43, 1'b1, er, ec, eo);
      end

      // Reset wins over a simultaneous start.
      begin
         int nd;
         nd = 0;
         @(negedge clk);
         A = 8'h01; B = 8'h01; reset = 1'b1; start = 1'b1;
         @(negedge clk);
         reset = 1'b0; start = 1'b0;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || !ready) nd++;
         end
         check("reset_beats_start", 32'(nd), 32'd0);
      end

      // start held high for 6 edges with changing operands.
      begin
         logic [7:0]  ha[6];
         logic [7:0]  hb[6];
         logic [15:0] r1;
         logic        rdy4;
         int          nd;
         int          lat;
         nd = 0; r1 = '0; rdy4 = 1'b0;
         for (int j = 0; j < 6; j++) begin
            ha[j] = 8'(8'h11 * (j + 1));
            hb[j] = 8'(8'h03 + j);
         end
         @(negedge clk);
         A = ha[0]; B = hb[0]; Add_Sub = 1'b0; start = 1'b1;
         for (int j = 1; j < 6; j++) begin
            @(negedge clk);
            if (done) begin nd++; r1 = R; end
            if (j == 4) rdy4 = ready;
            A = ha[j]; B = hb[j];
         end
         @(negedge clk);
         if (done) nd++;
         start = 1'b0;
         model(ha[0], hb[0], 1'b0, er, ec, eo);
         check("hold_one_done", 32'(nd), 32'd1);
         check("hold_first_R",  32'(r1), 32'(er));
         check("hold_ready_back", 32'(rdy4), 32'd1);
         lat = 0;
         while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
         end
         model(ha[4], hb[4], 1'b0, er, ec, eo);
         check("hold_second_lat", 32'(lat), 32'd1);
         check("hold_second_R",   32'(R),   32'(er));
         @(negedge clk);
         check("hold_idle", 32'({done, ready}), 32'b01);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
